// File: rtl/muldiv_seq.sv
// muldiv_seq: sequential unsigned multiplier/divider.
// MUL is shift-add (LSB first), DIV is restoring division (MSB first). Each
// uses exactly WIDTH iteration cycles, followed by a single DONE cycle.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  input  logic [2:0]       funct3_alu,
  input  logic             Type_alu,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             stall
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  // a: accumulator (MUL) or partial remainder (DIV)
  // b: shifting multiplicand (MUL) or divisor (DIV)
  // c: shifting multiplier (MUL) or dividend/quotient shift register (DIV)
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             ready_q, busy_q, done_q;

  logic             accept;
  logic [WIDTH-1:0] mul_acc;
  logic [WIDTH:0]   rem_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem;
  logic [WIDTH-1:0] div_quo;

  // Only funct3 3'b011 is a multiply/divide request; anything else is ignored.
  assign accept = start && ready_q && (funct3_alu == 3'b011);

  // One shift-add step: add the multiplicand when the current multiplier LSB is set.
  assign mul_acc = a_q + (c_q[0] ? b_q : '0);

  // One restoring-division step: bring down the next dividend bit and subtract
  // the divisor if it fits. A zero divisor always fits, giving an all-ones quotient.
  assign rem_shift = {a_q, c_q[WIDTH-1]};
  assign div_ge    = (rem_shift >= {1'b0, b_q});
  assign div_rem   = div_ge ? WIDTH'(rem_shift - {1'b0, b_q}) : rem_shift[WIDTH-1:0];
  assign div_quo   = {c_q[WIDTH-2:0], div_ge};

  // Next-state and datapath computation.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d = '0;
          a_d   = '0;
          if (Type_alu) begin
            state_d = MUL;
            b_d     = operand1;
            c_d     = operand2;
          end else begin
            state_d = DIV;
            b_d     = operand2;
            c_d     = operand1;
          end
        end
      end
      MUL: begin
        a_d   = mul_acc;
        b_d   = b_q << 1;
        c_d   = c_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d  = DONE;
          cnt_d    = '0;
          result_d = mul_acc;
        end
      end
      DIV: begin
        a_d   = div_rem;
        c_d   = div_quo;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d  = DONE;
          cnt_d    = '0;
          result_d = div_quo;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and status registers; status flags are decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      result_q <= '0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      result_q <= result_d;
      ready_q  <= (state_d == IDLE);
      busy_q   <= (state_d == MUL) || (state_d == DIV);
      done_q   <= (state_d == DONE);
    end
  end

  assign ready  = ready_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  // A valid request arriving while not ready must hold the pipeline.
  assign stall  = busy_q || (start && (funct3_alu == 3'b011) && !ready_q);

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed and randomized checks of muldiv_seq against a
// cycle-level behavioural model of the request/latency/result rules.
module tb_muldiv_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] operand1 = '0;
  logic [W-1:0] operand2 = '0;
  logic [2:0]   funct3_alu = 3'b000;
  logic         Type_alu = 1'b0;
  logic         ready, busy, done, stall;
  logic [W-1:0] result;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;

  muldiv_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .operand1(operand1), .operand2(operand2),
    .funct3_alu(funct3_alu), .Type_alu(Type_alu), .ready(ready), .busy(busy),
    .done(done), .result(result), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 = waiting, 1..W = computing, W+1 = completion cycle.
  int           m_phase = 0;
  logic [W-1:0] m_pending = '0;
  logic [W-1:0] m_result = '0;
  logic         m_valid = 1'b0;

  // Model update at each rising edge, then compare DUT outputs shortly after.
  always begin
    @(posedge clk);
    if (rst) begin
      m_phase  = 0;
      m_result = '0;
      m_valid  = 1'b1;
    end else if (m_phase == 0) begin
      if (start && funct3_alu == 3'b011) begin
        m_phase = 1;
        if (Type_alu) m_pending = operand1 * operand2;
        else if (operand2 == 0) m_pending = '1;
        else m_pending = operand1 / operand2;
      end
    end else if (m_phase < W) begin
      m_phase++;
    end else if (m_phase == W) begin
      m_phase  = W + 1;
      m_result = m_pending;
    end else begin
      m_phase = 0;
    end
    #1;
    if (m_valid) begin
      chk("ready", 64'(ready), 64'(m_phase == 0));
      chk("busy",  64'(busy),  64'(m_phase >= 1 && m_phase <= W));
      chk("done",  64'(done),  64'(m_phase == W + 1));
      chk("result", 64'(result), 64'(m_result));
      chk("stall", 64'(stall),
          64'((m_phase >= 1 && m_phase <= W) || (start && funct3_alu == 3'b011 && m_phase != 0)));
    end
    if (done === 1'b1) done_cnt++;
  end

  task automatic wait_done(output logic ok, output int nbusy);
    ok = 1'b0;
    nbusy = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      if (busy === 1'b1) nbusy++;
    end
  endtask

  task automatic issue(input logic typ, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start = 1'b1; funct3_alu = 3'b011; Type_alu = typ; operand1 = a; operand2 = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    logic ok;
    int   nb;
    int   dc;
    logic [W-1:0] ra, rb;

    // Reset
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_ready", 64'(ready), 64'd1);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_result", 64'(result), 64'd0);
    chk("reset_stall", 64'(stall), 64'd0);

    // MUL 0x3FFFFFFF * 3
    issue(1'b1, 32'h3FFF_FFFF, 32'h0000_0003);
    wait_done(ok, nb);
    chk("mul_timeout", 64'(ok), 64'd1);
    chk("mul_busy_cycles", 64'(nb + 1), 64'd32);
    chk("mul_result", 64'(result), 64'h0000_0000_BFFF_FFFD);
    @(negedge clk);
    chk("mul_ready_after", 64'(ready), 64'd1);

    // DIV same operands, operands disturbed while busy
    issue(1'b0, 32'h3FFF_FFFF, 32'h0000_0003);
    operand1 = 32'h0000_0001; operand2 = 32'h0000_0007; Type_alu = 1'b1;
    wait_done(ok, nb);
    chk("div_timeout", 64'(ok), 64'd1);
    chk("div_busy_cycles", 64'(nb + 1), 64'd32);
    chk("div_result", 64'(result), 64'h0000_0000_1555_5555);

    // DIV by zero
    issue(1'b0, 32'h1234_5678, 32'h0000_0000);
    wait_done(ok, nb);
    chk("div0_timeout", 64'(ok), 64'd1);
    chk("div0_busy_cycles", 64'(nb + 1), 64'd32);
    chk("div0_result", 64'(result), 64'h0000_0000_FFFF_FFFF);

    // Back-to-back: start held high across a MUL then a DIV
    @(negedge clk);
    start = 1'b1; funct3_alu = 3'b011; Type_alu = 1'b1;
    operand1 = 32'h3FFF_FFFF; operand2 = 32'h0000_0003;
    @(negedge clk);
    chk("b2b_first_busy", 64'(busy), 64'd1);
    Type_alu = 1'b0;
    wait_done(ok, nb);
    chk("b2b_first_timeout", 64'(ok), 64'd1);
    chk("b2b_first_result", 64'(result), 64'h0000_0000_BFFF_FFFD);
    chk("b2b_stall_in_done", 64'(stall), 64'd1);
    @(negedge clk);
    chk("b2b_dead_cycle_ready", 64'(ready), 64'd1);
    @(negedge clk);
    chk("b2b_second_busy", 64'(busy), 64'd1);
    start = 1'b0;
    wait_done(ok, nb);
    chk("b2b_second_timeout", 64'(ok), 64'd1);
    chk("b2b_second_result", 64'(result), 64'h0000_0000_1555_5555);

    // Ignored request
    dc = done_cnt;
    @(negedge clk);
    start = 1'b1; funct3_alu = 3'b000; Type_alu = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("ign_ready", 64'(ready), 64'd1);
      chk("ign_stall", 64'(stall), 64'd0);
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("ign_no_done", 64'(done_cnt), 64'(dc));

    // Reset at iteration 10 of a MUL
    issue(1'b1, 32'h0000_1234, 32'h0000_5678);
    repeat (9) @(negedge clk);
    dc = done_cnt;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_ready", 64'(ready), 64'd1);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_result", 64'(result), 64'd0);
    repeat (40) @(negedge clk);
    chk("rst_mid_no_done", 64'(done_cnt), 64'(dc));

    // MUL by zero and DIV of zero
    issue(1'b1, 32'hDEAD_BEEF, 32'h0000_0000);
    wait_done(ok, nb);
    chk("mul0_result", 64'(result), 64'd0);
    issue(1'b0, 32'h0000_0000, 32'h0000_0009);
    wait_done(ok, nb);
    chk("div_of0_result", 64'(result), 64'd0);

    // Randomized operations
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      case ($urandom_range(0, 3))
        0: ra = '0;
        1: ra = W'($urandom_range(0, 255));
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 4))
        0: rb = '0;
        1: rb = W'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 5) == 0) begin
        @(negedge clk);
        start = 1'b1; funct3_alu = 3'($urandom_range(0, 2)); Type_alu = 1'($urandom);
        operand1 = ra; operand2 = rb;
        repeat (2) @(negedge clk);
        start = 1'b0;
      end else begin
        issue(1'($urandom), ra, rb);
        wait_done(ok, nb);
        chk("rand_timeout", 64'(ok), 64'd1);
      end
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
